// File: rtl/fcl1_load_ctrl_if.sv
// Bundle between the pool2 stage, the loader and the FCL1 block: four channel
// vectors with per-channel valid/ack, the loaded FCL1 input vectors and the
// FCL1 launch/done handshake.
interface fcl1_load_ctrl_if #(
  parameter int DATA_W = 112
);
  logic [DATA_W-1:0] pool_data_1;
  logic [DATA_W-1:0] pool_data_2;
  logic [DATA_W-1:0] pool_data_3;
  logic [DATA_W-1:0] pool_data_4;
  logic [3:0]        pool_valid;
  logic [3:0]        pool_ack;
  logic [DATA_W-1:0] in_FCL1_1;
  logic [DATA_W-1:0] in_FCL1_2;
  logic [DATA_W-1:0] in_FCL1_3;
  logic [DATA_W-1:0] in_FCL1_4;
  logic              fcl_start;
  logic              fcl_done;

  // Producer/consumer side: supplies pool vectors and the FCL1 done pulse.
  modport master (
    output pool_data_1, pool_data_2, pool_data_3, pool_data_4,
    output pool_valid, fcl_done,
    input  pool_ack, in_FCL1_1, in_FCL1_2, in_FCL1_3, in_FCL1_4, fcl_start
  );

  // Loader side.
  modport slave (
    input  pool_data_1, pool_data_2, pool_data_3, pool_data_4,
    input  pool_valid, fcl_done,
    output pool_ack, in_FCL1_1, in_FCL1_2, in_FCL1_3, in_FCL1_4, fcl_start
  );
endinterface

// File: rtl/fcl1_load_ctrl.sv
// FCL1 load controller: captures the four pool2 channel vectors in order
// (with a programmable idle gap between captures), launches FCL1 with a
// one-cycle pulse, then waits for FCL1 completion and counts finished frames.
module fcl1_load_ctrl #(
  parameter int DATA_W = 112,
  parameter int GAP    = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             abort,
  fcl1_load_ctrl_if.slave  bus,
  output logic             busy,
  output logic             frame_done,
  output logic [7:0]       frame_cnt
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT,
    S_GAP,
    S_LAUNCH,
    S_HOLD
  } state_t;

  // Counter value loaded on entering the gap; only used when GAP > 0.
  localparam logic [3:0] GAP_LOAD = (GAP > 0) ? 4'(GAP - 1) : 4'd0;

  state_t     state;
  logic [1:0] ch_idx;
  logic [3:0] gap_cnt;
  logic       capture;
  logic [3:0] ack;

  // A capture happens only for the channel currently awaited, and abort
  // suppresses it outright.
  assign capture = (state == S_WAIT) && !abort && bus.pool_valid[ch_idx];

  // One-hot acknowledge of the captured channel.
  always_comb begin
    ack = 4'b0000;
    if (capture) ack[ch_idx] = 1'b1;
  end

  assign bus.pool_ack = ack;
  assign busy         = (state != S_IDLE);

  // Frame sequencer with registered launch/done pulses and capture registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state         <= S_IDLE;
      ch_idx        <= 2'd0;
      gap_cnt       <= 4'd0;
      bus.fcl_start <= 1'b0;
      frame_done    <= 1'b0;
      frame_cnt     <= 8'd0;
      bus.in_FCL1_1 <= '0;
      bus.in_FCL1_2 <= '0;
      bus.in_FCL1_3 <= '0;
      bus.in_FCL1_4 <= '0;
    end else begin
      bus.fcl_start <= 1'b0;
      frame_done    <= 1'b0;
      if (abort) begin
        // Cancel wins over every other event; captured vectors are kept.
        state   <= S_IDLE;
        ch_idx  <= 2'd0;
        gap_cnt <= 4'd0;
      end else begin
        case (state)
          S_IDLE: begin
            if (start) begin
              state  <= S_WAIT;
              ch_idx <= 2'd0;
            end
          end
          S_WAIT: begin
            if (bus.pool_valid[ch_idx]) begin
              case (ch_idx)
                2'd0:    bus.in_FCL1_1 <= bus.pool_data_1;
                2'd1:    bus.in_FCL1_2 <= bus.pool_data_2;
                2'd2:    bus.in_FCL1_3 <= bus.pool_data_3;
                default: bus.in_FCL1_4 <= bus.pool_data_4;
              endcase
              if (ch_idx == 2'd3) begin
                state         <= S_LAUNCH;
                bus.fcl_start <= 1'b1;
              end else if (GAP > 0) begin
                state   <= S_GAP;
                gap_cnt <= GAP_LOAD;
              end else begin
                ch_idx <= ch_idx + 2'd1;
              end
            end
          end
          S_GAP: begin
            if (gap_cnt == 4'd0) begin
              state  <= S_WAIT;
              ch_idx <= ch_idx + 2'd1;
            end else begin
              gap_cnt <= gap_cnt - 4'd1;
            end
          end
          S_LAUNCH: begin
            state <= S_HOLD;
          end
          S_HOLD: begin
            if (bus.fcl_done) begin
              state      <= S_IDLE;
              ch_idx     <= 2'd0;
              frame_done <= 1'b1;
              frame_cnt  <= frame_cnt + 8'd1;
            end
          end
          default: begin
            state  <= S_IDLE;
            ch_idx <= 2'd0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_fcl1_load_ctrl.sv
// Directed bench for fcl1_load_ctrl: one instance with GAP=2 and one with
// GAP=0. Captured vectors are predicted through per-instance queues filled
// when pool data is driven and drained when FCL1 is launched.
module tb_fcl1_load_ctrl;
  localparam int DW = 112;

  logic       clk;
  logic       rst_a, rst_b;
  logic       start_a, start_b;
  logic       abort_a, abort_b;
  logic       busy_a, busy_b;
  logic       frame_done_a, frame_done_b;
  logic [7:0] frame_cnt_a, frame_cnt_b;

  int errors = 0;
  int checks = 0;

  logic [DW-1:0] sb_a[$];
  logic [DW-1:0] sb_b[$];

  fcl1_load_ctrl_if #(.DATA_W(DW)) bus_a();
  fcl1_load_ctrl_if #(.DATA_W(DW)) bus_b();

  fcl1_load_ctrl #(.DATA_W(DW), .GAP(2)) dut_a (
    .clk(clk), .rst(rst_a), .start(start_a), .abort(abort_a), .bus(bus_a),
    .busy(busy_a), .frame_done(frame_done_a), .frame_cnt(frame_cnt_a)
  );

  fcl1_load_ctrl #(.DATA_W(DW), .GAP(0)) dut_b (
    .clk(clk), .rst(rst_b), .start(start_b), .abort(abort_b), .bus(bus_b),
    .busy(busy_b), .frame_done(frame_done_b), .frame_cnt(frame_cnt_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [3:0] ack_of(input bit b);
    return b ? bus_b.pool_ack : bus_a.pool_ack;
  endfunction

  function automatic logic fstart_of(input bit b);
    return b ? bus_b.fcl_start : bus_a.fcl_start;
  endfunction

  function automatic logic [DW-1:0] infcl_of(input bit b, input int k);
    logic [DW-1:0] v;
    case (k)
      0:       v = b ? bus_b.in_FCL1_1 : bus_a.in_FCL1_1;
      1:       v = b ? bus_b.in_FCL1_2 : bus_a.in_FCL1_2;
      2:       v = b ? bus_b.in_FCL1_3 : bus_a.in_FCL1_3;
      default: v = b ? bus_b.in_FCL1_4 : bus_a.in_FCL1_4;
    endcase
    return v;
  endfunction

  task automatic set_ctl(input bit b, input logic st, input logic ab, input logic [3:0] pv, input logic fd);
    if (b) begin
      start_b = st; abort_b = ab; bus_b.pool_valid = pv; bus_b.fcl_done = fd;
    end else begin
      start_a = st; abort_a = ab; bus_a.pool_valid = pv; bus_a.fcl_done = fd;
    end
  endtask

  task automatic load_data(input bit b, input logic [DW-1:0] d1, input logic [DW-1:0] d2,
                           input logic [DW-1:0] d3, input logic [DW-1:0] d4, input bit push);
    if (b) begin
      bus_b.pool_data_1 = d1; bus_b.pool_data_2 = d2; bus_b.pool_data_3 = d3; bus_b.pool_data_4 = d4;
      if (push) begin sb_b.push_back(d1); sb_b.push_back(d2); sb_b.push_back(d3); sb_b.push_back(d4); end
    end else begin
      bus_a.pool_data_1 = d1; bus_a.pool_data_2 = d2; bus_a.pool_data_3 = d3; bus_a.pool_data_4 = d4;
      if (push) begin sb_a.push_back(d1); sb_a.push_back(d2); sb_a.push_back(d3); sb_a.push_back(d4); end
    end
  endtask

  task automatic pop_cmp(input bit b, input string tag);
    logic [DW-1:0] exp;
    for (int k = 0; k < 4; k++) begin
      if ((b ? sb_b.size() : sb_a.size()) == 0) begin
        chk({tag, "_sb_empty"}, 0, 1);
      end else begin
        exp = b ? sb_b.pop_front() : sb_a.pop_front();
        chk($sformatf("%s_in_fcl1_%0d", tag, k + 1), infcl_of(b, k), exp);
      end
    end
  endtask

  // Waits (bounded) for the launch pulse; returns positioned in the LAUNCH cycle.
  task automatic wait_launch(input bit b, input string tag);
    bit seen = 1'b0;
    for (int i = 0; i < 40 && !seen; i++) begin
      @(negedge clk);
      if (b) start_b = 1'b0; else start_a = 1'b0;
      #1;
      if (fstart_of(b)) seen = 1'b1;
    end
    chk({tag, "_launch_seen"}, seen, 1);
  endtask

  // From the LAUNCH cycle: HOLD, fcl_done, then one frame_done pulse.
  task automatic end_frame(input bit b, input logic [7:0] exp_cnt, input string tag);
    @(negedge clk); #1;
    chk({tag, "_hold_busy"}, b ? busy_b : busy_a, 1);
    chk({tag, "_hold_fstart"}, fstart_of(b), 0);
    set_ctl(b, 1'b0, 1'b0, 4'hF, 1'b1);
    @(negedge clk);
    set_ctl(b, 1'b0, 1'b0, 4'hF, 1'b0);
    #1;
    chk({tag, "_frame_done"}, b ? frame_done_b : frame_done_a, 1);
    chk({tag, "_frame_cnt"}, b ? frame_cnt_b : frame_cnt_a, exp_cnt);
    chk({tag, "_idle"}, b ? busy_b : busy_a, 0);
    @(negedge clk); #1;
    chk({tag, "_frame_done_low"}, b ? frame_done_b : frame_done_a, 0);
  endtask

  initial begin
    logic [3:0] exp_ack;
    rst_a = 1'b1; rst_b = 1'b1;
    set_ctl(0, 1'b0, 1'b0, 4'hF, 1'b0);
    set_ctl(1, 1'b0, 1'b0, 4'hF, 1'b0);
    load_data(0, '0, '0, '0, '0, 0);
    load_data(1, '0, '0, '0, '0, 0);
    #2 rst_a = 1'b0; rst_b = 1'b0;
    #1;
    chk("rst_busy", busy_a, 0);
    chk("rst_ack", bus_a.pool_ack, 0);
    chk("rst_fstart", bus_a.fcl_start, 0);
    chk("rst_fdone", frame_done_a, 0);
    chk("rst_fcnt", frame_cnt_a, 0);
    chk("rst_in1", bus_a.in_FCL1_1, 0);
    chk("rst_b_busy", busy_b, 0);
    @(negedge clk);
    @(negedge clk);
    rst_a = 1'b1; rst_b = 1'b1;
    set_ctl(0, 1'b0, 1'b0, 4'h0, 1'b0);
    set_ctl(1, 1'b0, 1'b0, 4'h0, 1'b0);

    // GAP=2 nominal frame, valid held, data k*0x11.
    @(negedge clk);
    load_data(0, 'h11, 'h22, 'h33, 'h44, 1);
    set_ctl(0, 1'b1, 1'b0, 4'hF, 1'b0);
    #1 chk("g2_c0_busy", busy_a, 0);
    for (int c = 1; c <= 11; c++) begin
      @(negedge clk);
      start_a = 1'b0;
      #1;
      exp_ack = (c == 1) ? 4'b0001 : (c == 4) ? 4'b0010 : (c == 7) ? 4'b0100 : (c == 10) ? 4'b1000 : 4'b0000;
      chk($sformatf("g2_ack_c%0d", c), bus_a.pool_ack, exp_ack);
      chk($sformatf("g2_fstart_c%0d", c), bus_a.fcl_start, (c == 11));
      chk($sformatf("g2_busy_c%0d", c), busy_a, 1);
    end
    pop_cmp(0, "g2");
    end_frame(0, 8'd1, "g2");
    // fcl_done while idle must not count.
    set_ctl(0, 1'b0, 1'b0, 4'h0, 1'b1);
    @(negedge clk);
    set_ctl(0, 1'b0, 1'b0, 4'h0, 1'b0);
    #1;
    chk("idle_done_cnt", frame_cnt_a, 1);
    chk("idle_done_pulse", frame_done_a, 0);

    // Channel 1 missing: stall in WAIT, other valids ignored.
    @(negedge clk);
    load_data(0, 'h55, 'h66, 'h77, 'h88, 1);
    set_ctl(0, 1'b1, 1'b0, 4'b1110, 1'b0);
    for (int c = 1; c <= 20; c++) begin
      @(negedge clk);
      start_a = 1'b0;
      #1;
      chk($sformatf("stall_ack_c%0d", c), bus_a.pool_ack, 0);
      chk($sformatf("stall_busy_c%0d", c), busy_a, 1);
    end
    @(negedge clk);
    bus_a.pool_valid = 4'hF;
    #1 chk("stall_release_ack", bus_a.pool_ack, 4'b0001);
    wait_launch(0, "stall");
    pop_cmp(0, "stall");
    end_frame(0, 8'd2, "stall");

    // Abort in GAP after the second capture.
    @(negedge clk);
    load_data(0, 'hA1, 'hA2, 'hA3, 'hA4, 0);
    sb_a.push_back('hA1); sb_a.push_back('hA2); sb_a.push_back('h77); sb_a.push_back('h88);
    set_ctl(0, 1'b1, 1'b0, 4'hF, 1'b0);
    for (int c = 1; c <= 4; c++) begin
      @(negedge clk);
      start_a = 1'b0;
      #1;
      exp_ack = (c == 1) ? 4'b0001 : (c == 4) ? 4'b0010 : 4'b0000;
      chk($sformatf("ab_ack_c%0d", c), bus_a.pool_ack, exp_ack);
    end
    @(negedge clk);
    abort_a = 1'b1;
    #1;
    chk("ab_gap_ack", bus_a.pool_ack, 0);
    chk("ab_gap_busy", busy_a, 1);
    @(negedge clk);
    abort_a = 1'b0;
    #1;
    chk("ab_idle", busy_a, 0);
    chk("ab_fcnt", frame_cnt_a, 2);
    pop_cmp(0, "ab_keep");
    for (int c = 0; c < 10; c++) begin
      @(negedge clk); #1;
      chk("ab_no_fstart", bus_a.fcl_start, 0);
      chk("ab_stay_idle", busy_a, 0);
    end
    // Abort beats a simultaneous start.
    @(negedge clk);
    set_ctl(0, 1'b1, 1'b1, 4'hF, 1'b0);
    @(negedge clk);
    set_ctl(0, 1'b0, 1'b0, 4'hF, 1'b0);
    #1 chk("ab_vs_start", busy_a, 0);
    // Abort beats a pending capture in WAIT.
    load_data(0, 'hEE, 'hEF, 'hF0, 'hF1, 0);
    set_ctl(0, 1'b1, 1'b0, 4'hF, 1'b0);
    @(negedge clk);
    set_ctl(0, 1'b0, 1'b1, 4'hF, 1'b0);
    #1 chk("ab_wait_ack", bus_a.pool_ack, 0);
    @(negedge clk);
    set_ctl(0, 1'b0, 1'b0, 4'h0, 1'b0);
    #1;
    chk("ab_wait_idle", busy_a, 0);
    chk("ab_wait_nocap", bus_a.in_FCL1_1, 'hA1);
    chk("ab_wait_fcnt", frame_cnt_a, 2);

    // GAP=0: back-to-back captures.
    @(negedge clk);
    load_data(1, 'hB1, 'hB2, 'hB3, 'hB4, 1);
    set_ctl(1, 1'b1, 1'b0, 4'hF, 1'b0);
    for (int c = 1; c <= 5; c++) begin
      @(negedge clk);
      start_b = 1'b0;
      #1;
      exp_ack = (c < 5) ? (4'b0001 << (c - 1)) : 4'b0000;
      chk($sformatf("g0_ack_c%0d", c), bus_b.pool_ack, exp_ack);
      chk($sformatf("g0_fstart_c%0d", c), bus_b.fcl_start, (c == 5));
    end
    pop_cmp(1, "g0");
    end_frame(1, 8'd1, "g0");

    // Frame counter wrap: frames 2..256 on the GAP=0 instance.
    for (int f = 2; f <= 256; f++) begin
      @(negedge clk);
      load_data(1, DW'(f * 4 + 1), DW'(f * 4 + 2), DW'(f * 4 + 3), DW'(f * 4 + 4), 1);
      set_ctl(1, 1'b1, 1'b0, 4'hF, 1'b0);
      wait_launch(1, "wrap");
      pop_cmp(1, "wrap");
      end_frame(1, 8'(f), $sformatf("wrap_f%0d", f));
    end

    // Asynchronous reset while in HOLD.
    @(negedge clk);
    load_data(0, 'hC1, 'hC2, 'hC3, 'hC4, 1);
    set_ctl(0, 1'b1, 1'b0, 4'hF, 1'b0);
    wait_launch(0, "rh");
    pop_cmp(0, "rh");
    @(negedge clk);
    #2 rst_a = 1'b0;
    #1;
    chk("rh_busy", busy_a, 0);
    chk("rh_fstart", bus_a.fcl_start, 0);
    chk("rh_fdone", frame_done_a, 0);
    chk("rh_fcnt", frame_cnt_a, 0);
    chk("rh_in1", bus_a.in_FCL1_1, 0);
    chk("rh_in4", bus_a.in_FCL1_4, 0);
    chk("rh_ack", bus_a.pool_ack, 0);
    @(negedge clk);
    rst_a = 1'b1;
    set_ctl(0, 1'b0, 1'b0, 4'h0, 1'b0);
    @(negedge clk);
    bus_a.fcl_done = 1'b1;
    @(negedge clk);
    bus_a.fcl_done = 1'b0;
    #1;
    chk("rh_late_done", frame_done_a, 0);
    chk("rh_late_cnt", frame_cnt_a, 0);
    chk("rh_late_busy", busy_a, 0);
    @(negedge clk); #1;
    chk("rh_late_done2", frame_done_a, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
